alu_exec: RTL
=============

// Module: alu_exec
// PURPOSE
//   Execute-stage ALU directly downstream of the registered operand-B mux.
//   - Consumes operand A (readData1) and operand B (registered mux output: readData2 or imm).
//   - Computes the aluOp result and presents it with a zero flag to the memory/writeback stage.
//   - Uses a valid/ready handshake on both sides.
//   - Single-cycle ops complete in one cycle; optional MUL runs as an iterative multi-cycle op.
// PARAMETERS
//   DATA_W   32                 operand/result width
//   SHAMT_W  $clog2(DATA_W)=5   shift-amount bits taken from operandB
// PORTS
//   clock       in   1       single clock, rising edge
//   reset       in   1       asynchronous, active-low reset
//   in_valid    in   1       operands/aluOp valid this cycle
//   in_ready    out  1       block accepts operands this cycle
//   aluOp       in   4       operation select (encoding in alu_pkg)
//   operandA    in   DATA_W  rs1 value
//   operandB    in   DATA_W  operand-B mux output
//   out_valid   out  1       aluResult/zero valid
//   out_ready   in   1       downstream accepts result
//   aluResult   out  DATA_W  registered result
//   zero        out  1       registered (aluResult == 0); meaningful only while out_valid=1
// BEHAVIOUR
//   Reset (reset=0, async) values:
//     - state=IDLE, out_valid=0, aluResult=0, zero=0, internal mul regs=0.
//     - Reset mid-MUL abandons the op; no result is produced.
//   Acceptance:
//     - Transfer occurs when in_valid && in_ready.
//     - in_ready = (state==IDLE) || (state==DONE && out_ready).
//     - Result drain and new accept may share a cycle (back-to-back).
//   States:
//     - IDLE -> DONE on accept of a single-cycle op. Result registered at that edge, so latency is 1 cycle.
//     - IDLE/DONE -> MUL on accept of MUL.
//     - MUL -> DONE after DATA_W iterations. out_valid rises on cycle DATA_W+1 after accept.
//     - DONE holds aluResult/zero/out_valid stable until out_ready=1.
//     - DONE with out_ready=1 and no accept -> IDLE.
//   Ops, all modulo 2^DATA_W (wrap-around, no overflow flag):
//     - ADD, SUB, AND, OR, XOR.
//     - SLL/SRL/SRA: shift by operandB[SHAMT_W-1:0]. SRA sign-fills from operandA[DATA_W-1].
//     - SLT (signed) / SLTU (unsigned): result 1 or 0, zero-extended.
//     - Reserved aluOp codes: single-cycle, result 0, zero=1.
//   Operands are sampled only at accept. Input changes while busy are ignored.
//   in_valid while in MUL: in_ready=0, and the input must be held by upstream.
// CONFIGURATION
//   ALU_MUL_EN defined:
//     - aluOp MUL = iterative shift-add, low DATA_W bits of A*B (signedness irrelevant for low half).
//   ALU_MUL_EN undefined:
//     - MUL is treated as a reserved code (1-cycle, result 0).
//     - No MUL state or multiplier logic is built.
// STRUCTURE
//   alu_pkg:
//     - aluOp localparams: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9 MUL=10.
//     - State encodings: IDLE/MUL/DONE.
//   Sub-module alu_mul_iter:
//     - Instantiated only under ALU_MUL_EN.
//     - Interface: start, operands, done pulse, product.
//     - Owns the multiplicand/multiplier shift regs and the iteration counter.
//   Top level: FSM, handshake, combinational single-cycle datapath, result/zero regs.
// TESTING
//   1. Reset: hold reset=0 with in_valid=1 -> out_valid=0, aluResult=0, zero=0; no accept until reset=1.
//   2. ADD wrap: A=32'hFFFF_FFFF, B=1, out_ready=1 -> next cycle out_valid=1, aluResult=0, zero=1.
//      Then SUB A=5, B=7 -> 32'hFFFF_FFFE.
//   3. Shifts/compare:
//      - SRA A=32'h8000_0000, B=32'h0000_0024 (shamt 4) -> 32'hF800_0000.
//      - SLT A=-1, B=1 -> 1.
//      - SLTU A=-1, B=1 -> 0.
//   4. Backpressure: ADD 3+4 with out_ready=0 for 5 cycles -> aluResult=7 held, in_ready=0.
//      Raising out_ready with in_valid=1 (XOR) drains and accepts in the same cycle.
//   5. MUL (ALU_MUL_EN): A=32'h0001_0003, B=32'h0000_0005 -> out_valid on cycle 33 after accept, aluResult=32'h0005_000F.
//      Without ALU_MUL_EN the same stimulus gives 0 after 1 cycle.
//   6. Reset mid-MUL: assert reset=0 at iteration 10 -> immediate IDLE, out_valid=0.
//      After release, ADD 1+1 gives 2 with 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, FSM states, default width.
package alu_pkg;

   localparam int ALU_DATA_W = 32;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W bits of A*B.
// done is asserted combinationally during the last iteration, with product holding the final sum.
module alu_mul_iter #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = $clog2(DATA_W);

   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] acc_next_s;

   // Next-state for the shift registers, accumulator and iteration counter.
   always_comb begin
      acc_next_s = acc_q + (mplier_q[0] ? mcand_q : {DATA_W{1'b0}});
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      if (start) begin
         mcand_d  = op_a;
         mplier_d = op_b;
         acc_d    = {DATA_W{1'b0}};
         cnt_d    = {CNT_W{1'b0}};
         busy_d   = 1'b1;
      end else if (busy_q) begin
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         acc_d    = acc_next_s;
         cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         if (cnt_q == CNT_W'(DATA_W-1)) begin
            busy_d = 1'b0;
         end else begin
            busy_d = 1'b1;
         end
      end else begin
         busy_d = 1'b0;
      end
   end

   assign done    = busy_q && (cnt_q == CNT_W'(DATA_W-1));
   assign product = acc_next_s;

   // Multiplier state registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mcand_q  <= {DATA_W{1'b0}};
         mplier_q <= {DATA_W{1'b0}};
         acc_q    <= {DATA_W{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready on both sides; result and zero flag are registered.
// Define ALU_MUL_EN to build the iterative MUL; otherwise MUL behaves as a reserved code.
module alu_exec
   import alu_pkg::*;
#(
   parameter int DATA_W  = ALU_DATA_W,
   parameter int SHAMT_W = $clog2(DATA_W)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        aluOp,
   input  logic [DATA_W-1:0] operandA,
   input  logic [DATA_W-1:0] operandB,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] aluResult,
   output logic              zero
);

   alu_state_t        state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              zero_q, zero_d;
   logic [DATA_W-1:0] res_s;
   logic [SHAMT_W-1:0] shamt_s;
   logic              accept_s;
   logic              is_mul_s;
   logic              mul_done_s;
   logic [DATA_W-1:0] mul_prod_s;

   assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign accept_s = in_valid && in_ready;
   assign shamt_s  = operandB[SHAMT_W-1:0];

`ifdef ALU_MUL_EN
   assign is_mul_s = (aluOp == OP_MUL);

   alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
      .clock   (clock),
      .reset   (reset),
      .start   (accept_s && is_mul_s),
      .op_a    (operandA),
      .op_b    (operandB),
      .done    (mul_done_s),
      .product (mul_prod_s)
   );
`else
   assign is_mul_s   = 1'b0;
   assign mul_done_s = 1'b0;
   assign mul_prod_s = {DATA_W{1'b0}};
`endif

   // Single-cycle datapath; unlisted codes (and MUL when not built) yield zero.
   always_comb begin
      case (aluOp)
         OP_ADD:  res_s = operandA + operandB;
         OP_SUB:  res_s = operandA - operandB;
         OP_AND:  res_s = operandA & operandB;
         OP_OR:   res_s = operandA | operandB;
         OP_XOR:  res_s = operandA ^ operandB;
         OP_SLL:  res_s = operandA << shamt_s;
         OP_SRL:  res_s = operandA >> shamt_s;
         OP_SRA:  res_s = $signed(operandA) >>> shamt_s;
         OP_SLT:  res_s = {{(DATA_W-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
         OP_SLTU: res_s = {{(DATA_W-1){1'b0}}, (operandA < operandB)};
         default: res_s = {DATA_W{1'b0}};
      endcase
   end

   // FSM next state and registered output updates.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept_s && is_mul_s) begin
               state_d     = ST_MUL;
               out_valid_d = 1'b0;
            end else if (accept_s) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               result_d    = res_s;
               zero_d      = (res_s == {DATA_W{1'b0}});
            end else if ((state_q == ST_DONE) && out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end else begin
               state_d     = state_q;
            end
         end
         ST_MUL: begin
            if (mul_done_s) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               result_d    = mul_prod_s;
               zero_d      = (mul_prod_s == {DATA_W{1'b0}});
            end else begin
               state_d     = ST_MUL;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= {DATA_W{1'b0}};
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
      end
   end

   assign out_valid = out_valid_q;
   assign aluResult = result_q;
   assign zero      = zero_q;

endmodule
